csc_stream_pipe: RTL and testbench
==================================

# csc_stream_pipe

Parametrised, fully pipelined colour-space converter with a valid/ready streaming interface, per-pixel conversion mode and sideband pass-through. It is the streaming successor of the registered single-cycle converter, and sits between the video capture front end and the image-processing cores. It supports RGB, YUV (BT.601 full-range YCbCr) and CMY in any direction, clamps every result and propagates backpressure.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per colour component (8..12)
- USER_WIDTH, 2, sideband bits carried unchanged with each pixel (e.g. sof/eol)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_c1, in_c2, in_c3  in  DATA_WIDTH each  input components (R/G/B, Y/Cb/Cr or C/M/Y)
- in_src  in  2  source space of this beat: 0 RGB, 1 YUV, 2 CMY, 3 reserved
- in_dst  in  2  destination space, same encoding
- in_user  in  USER_WIDTH  sideband
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_c1, out_c2, out_c3  out  DATA_WIDTH each  converted components
- out_user  out  USER_WIDTH  sideband delayed with its pixel
- out_err  out  1  beat had src or dst = 3; components passed through unchanged

## Operation
- OFF = 2^(DATA_WIDTH-1), MAX = 2^DATA_WIDTH-1; coefficients Q8 signed; ">>>" is an arithmetic shift; every product sum adds +128 before >>>8 (round half up).
- Mode is carried with the pixel through every stage; consecutive beats may use different modes, with no flush and no bubble.
- Stage 1 (to RGB):
  - RGB: pass.
  - CMY: bitwise invert.
  - YUV: dCb = Cb-OFF, dCr = Cr-OFF (signed); products 359·dCr, 88·dCb, 183·dCr, 454·dCb registered.
- Stage 2 (RGB finalise):
  - YUV source: R = Y + ((359dCr+128)>>>8); G = Y - ((88dCb+183dCr+128)>>>8); B = Y + ((454dCb+128)>>>8).
  - Each result clamped to [0, MAX].
- Stage 3 (from RGB): products 77R, 150G, 29B, -43R, -85G, 128B, 128R, -107G, -21B registered.
- Stage 4 (output):
  - dst YUV: Y = (sum+128)>>>8; Cb and Cr = ((sum+128)>>>8) + OFF; each clamped to [0, MAX].
  - dst RGB: RGB from stage 2.
  - dst CMY: inverted RGB.
- src == dst: stage 4 outputs the original input components bit-exact, with no round-trip error. Original inputs are delayed alongside for this case.
- src or dst = 3: original inputs pass through, out_err = 1. Otherwise out_err = 0.
- Internal widths must be sized so that no intermediate overflows before the clamp.

## Timing
- Latency is 4 cycles from input handshake (in_valid & in_ready) to out_valid, with no stalls.
- Throughput is 1 beat/cycle while out_ready = 1.
- Global advance: ce = ~out_valid | out_ready.
  - in_ready = ce, combinational from out_ready and out_valid only.
  - in_ready does not depend on in_valid.
- When ce = 0, every stage register, including the valid bits, holds. out_* remain stable while out_valid & ~out_ready.
- Empty slots (bubbles) propagate as valid = 0. Their data contents are don't-care but must not produce out_valid.
- Reset (async assert, sync release internally acceptable):
  - all stage valid bits = 0, out_valid = 0, out_c1..3 = 0, out_user = 0, out_err = 0;
  - in_ready = 1 after reset (since out_valid = 0).
- Reset mid-stream: all in-flight beats are discarded. After release, no output appears until new input is accepted.
- Simultaneous out_ready fall with in_valid: no beat is accepted that cycle. No beat is ever dropped or duplicated.

## Test plan
- RGB→YUV (DATA_WIDTH 8): (255,255,255) -> (255,128,128); (255,0,0) -> (77,85,255), where Cr is clamped from 256.
- YUV→RGB: (0,255,255) -> (178,0,225), where G is clamped from -134; (128,128,128) -> (128,128,128).
- CMY→YUV: (0,0,0) -> (255,128,128). RGB→CMY: (10,20,30) -> (245,235,225). YUV→YUV: (17,3,250) -> (17,3,250) bit-exact.
- Mixed-mode back-to-back stream of 8 beats with in_user incrementing: outputs in order, 4-cycle latency, out_user matches, and a beat with src = 3 yields out_err = 1 with inputs passed through.
- Random out_ready throttling over 1000 random beats: scoreboard against a reference model, with no loss or duplication and outputs stable while stalled.
- Assert reset_n low with 3 beats in flight: outputs go 0 immediately. After release, only post-reset beats emerge.

Source files
------------

// File: rtl/csc_stream_pipe.sv
// csc_stream_pipe: 4-stage valid/ready colour-space converter between RGB, YUV (BT.601 full range) and CMY.
// Mode, sideband and original components travel with each pixel; every stage advances on a shared ce.
module csc_stream_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_c1,
  input  logic [DATA_WIDTH-1:0] in_c2,
  input  logic [DATA_WIDTH-1:0] in_c3,
  input  logic [1:0]            in_src,
  input  logic [1:0]            in_dst,
  input  logic [USER_WIDTH-1:0] in_user,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_c1,
  output logic [DATA_WIDTH-1:0] out_c2,
  output logic [DATA_WIDTH-1:0] out_c3,
  output logic [USER_WIDTH-1:0] out_user,
  output logic                  out_err
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = DATA_WIDTH + 12;
  localparam logic [1:0] SP_RGB = 2'd0;
  localparam logic [1:0] SP_YUV = 2'd1;
  localparam logic [1:0] SP_CMY = 2'd2;
  localparam logic [1:0] SP_RSV = 2'd3;

  typedef logic signed [PW-1:0] wide_t;

  typedef struct packed {
    logic [1:0]            src;
    logic [1:0]            dst;
    logic [USER_WIDTH-1:0] user;
    logic [DW-1:0]         o1;
    logic [DW-1:0]         o2;
    logic [DW-1:0]         o3;
  } side_t;

  localparam wide_t OFF_W = wide_t'(2 ** (DW - 1));
  localparam wide_t MAX_W = wide_t'(2 ** DW - 1);
  localparam wide_t RND_W = wide_t'(128);

  function automatic wide_t ext(input logic [DW-1:0] x);
    return $signed({{(PW-DW){1'b0}}, x});
  endfunction

  function automatic wide_t rshift8(input wide_t v);
    return (v + RND_W) >>> 4'd8;
  endfunction

  function automatic logic [DW-1:0] clamp(input wide_t v);
    logic [DW-1:0] r;
    if (v < wide_t'(0)) begin
      r = '0;
    end else if (v > MAX_W) begin
      r = '1;
    end else begin
      r = v[DW-1:0];
    end
    return r;
  endfunction

  logic          ce_s;
  logic          s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
  side_t         s1_side_q, s1_side_d, s2_side_q, s2_side_d, s3_side_q, s3_side_d;
  logic [DW-1:0] s1_c_q[3], s1_c_d[3];
  wide_t         s1_p_q[4], s1_p_d[4];
  logic [DW-1:0] s2_rgb_q[3], s2_rgb_d[3], s3_rgb_q[3], s3_rgb_d[3];
  wide_t         s3_p_q[9], s3_p_d[9];
  logic          out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic [DW-1:0] out_c_q[3], out_c_d[3];
  logic [USER_WIDTH-1:0] out_user_q, out_user_d;

  assign ce_s     = ~out_valid_q | out_ready;
  assign in_ready = ce_s;

  // Stage 1: bring RGB/CMY to RGB, form the chroma products for a YUV source.
  always_comb begin
    wide_t dcb;
    wide_t dcr;
    s1_valid_d     = in_valid;
    s1_side_d.src  = in_src;
    s1_side_d.dst  = in_dst;
    s1_side_d.user = in_user;
    s1_side_d.o1   = in_c1;
    s1_side_d.o2   = in_c2;
    s1_side_d.o3   = in_c3;
    if (in_src == SP_CMY) begin
      s1_c_d[0] = ~in_c1;
      s1_c_d[1] = ~in_c2;
      s1_c_d[2] = ~in_c3;
    end else begin
      s1_c_d[0] = in_c1;
      s1_c_d[1] = in_c2;
      s1_c_d[2] = in_c3;
    end
    dcb       = ext(in_c2) - OFF_W;
    dcr       = ext(in_c3) - OFF_W;
    s1_p_d[0] = wide_t'(359) * dcr;
    s1_p_d[1] = wide_t'(88) * dcb;
    s1_p_d[2] = wide_t'(183) * dcr;
    s1_p_d[3] = wide_t'(454) * dcb;
  end

  // Stage 2: finalise RGB (only a YUV source needs arithmetic).
  always_comb begin
    wide_t y;
    s2_valid_d = s1_valid_q;
    s2_side_d  = s1_side_q;
    y          = ext(s1_c_q[0]);
    if (s1_side_q.src == SP_YUV) begin
      s2_rgb_d[0] = clamp(y + rshift8(s1_p_q[0]));
      s2_rgb_d[1] = clamp(y - rshift8(s1_p_q[1] + s1_p_q[2]));
      s2_rgb_d[2] = clamp(y + rshift8(s1_p_q[3]));
    end else begin
      s2_rgb_d = s1_c_q;
    end
  end

  // Stage 3: luma/chroma products from RGB.
  always_comb begin
    wide_t r;
    wide_t g;
    wide_t b;
    s3_valid_d = s2_valid_q;
    s3_side_d  = s2_side_q;
    s3_rgb_d   = s2_rgb_q;
    r          = ext(s2_rgb_q[0]);
    g          = ext(s2_rgb_q[1]);
    b          = ext(s2_rgb_q[2]);
    s3_p_d[0]  = wide_t'(77) * r;
    s3_p_d[1]  = wide_t'(150) * g;
    s3_p_d[2]  = wide_t'(29) * b;
    s3_p_d[3]  = wide_t'(-43) * r;
    s3_p_d[4]  = wide_t'(-85) * g;
    s3_p_d[5]  = wide_t'(128) * b;
    s3_p_d[6]  = wide_t'(128) * r;
    s3_p_d[7]  = wide_t'(-107) * g;
    s3_p_d[8]  = wide_t'(-21) * b;
  end

  // Stage 4: pick the destination form; same-space and reserved beats return the originals.
  always_comb begin
    wide_t ys;
    wide_t cbs;
    wide_t crs;
    out_valid_d = s3_valid_q;
    out_user_d  = s3_side_q.user;
    out_err_d   = 1'b0;
    ys          = rshift8(s3_p_q[0] + s3_p_q[1] + s3_p_q[2]);
    cbs         = rshift8(s3_p_q[3] + s3_p_q[4] + s3_p_q[5]) + OFF_W;
    crs         = rshift8(s3_p_q[6] + s3_p_q[7] + s3_p_q[8]) + OFF_W;
    out_c_d[0]  = s3_side_q.o1;
    out_c_d[1]  = s3_side_q.o2;
    out_c_d[2]  = s3_side_q.o3;
    if ((s3_side_q.src == SP_RSV) || (s3_side_q.dst == SP_RSV)) begin
      out_err_d = 1'b1;
    end else if (s3_side_q.src == s3_side_q.dst) begin
      out_err_d = 1'b0;
    end else begin
      case (s3_side_q.dst)
        SP_YUV: begin
          out_c_d[0] = clamp(ys);
          out_c_d[1] = clamp(cbs);
          out_c_d[2] = clamp(crs);
        end
        SP_CMY: begin
          out_c_d[0] = ~s3_rgb_q[0];
          out_c_d[1] = ~s3_rgb_q[1];
          out_c_d[2] = ~s3_rgb_q[2];
        end
        SP_RGB:  out_c_d = s3_rgb_q;
        default: out_c_d = s3_rgb_q;
      endcase
    end
  end

  // Pipeline registers: all stages hold together when the output is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_side_q   <= '0;
      s2_side_q   <= '0;
      s3_side_q   <= '0;
      s1_c_q      <= '{default: '0};
      s1_p_q      <= '{default: '0};
      s2_rgb_q    <= '{default: '0};
      s3_rgb_q    <= '{default: '0};
      s3_p_q      <= '{default: '0};
      out_c_q     <= '{default: '0};
      out_user_q  <= '0;
      out_err_q   <= 1'b0;
    end else if (ce_s) begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s3_valid_q  <= s3_valid_d;
      out_valid_q <= out_valid_d;
      s1_side_q   <= s1_side_d;
      s2_side_q   <= s2_side_d;
      s3_side_q   <= s3_side_d;
      s1_c_q      <= s1_c_d;
      s1_p_q      <= s1_p_d;
      s2_rgb_q    <= s2_rgb_d;
      s3_rgb_q    <= s3_rgb_d;
      s3_p_q      <= s3_p_d;
      out_c_q     <= out_c_d;
      out_user_q  <= out_user_d;
      out_err_q   <= out_err_d;
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_c1    = out_c_q[0];
  assign out_c2    = out_c_q[1];
  assign out_c3    = out_c_q[2];
  assign out_user  = out_user_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_csc_stream_pipe.sv
// Scoreboard bench for csc_stream_pipe: directed test-plan beats, throttled random traffic
// against an integer reference model, and reset with beats in flight.
module tb_csc_stream_pipe;

  localparam int DW   = 8;
  localparam int UW   = 2;
  localparam int MAXV = 2 ** DW - 1;
  localparam int OFFV = 2 ** (DW - 1);

  typedef logic [3*DW+UW:0] bund_t;

  logic          clk, reset_n, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [DW-1:0] in_c1, in_c2, in_c3, out_c1, out_c2, out_c3;
  logic [1:0]    in_src, in_dst;
  logic [UW-1:0] in_user, out_user;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  bit    thr      = 1'b0;
  bit    lat_chk  = 1'b0;
  bit    front_seen = 1'b0;
  bund_t exp_q[$];
  int    acc_q[$];

  csc_stream_pipe #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_c1(in_c1), .in_c2(in_c2), .in_c3(in_c3),
    .in_src(in_src), .in_dst(in_dst), .in_user(in_user),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c1(out_c1), .out_c2(out_c2), .out_c3(out_c3),
    .out_user(out_user), .out_err(out_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bund_t pack(input int a, input int b, input int c, input int u, input bit e);
    logic [DW-1:0] a8, b8, c8;
    logic [UW-1:0] u8;
    a8 = a[DW-1:0];
    b8 = b[DW-1:0];
    c8 = c[DW-1:0];
    u8 = u[UW-1:0];
    return {a8, b8, c8, u8, e};
  endfunction

  function automatic int clampi(input int v);
    return (v < 0) ? 0 : ((v > MAXV) ? MAXV : v);
  endfunction

  function automatic int rnd8(input int v);
    return (v + 128) >>> 8;
  endfunction

  // Reference: go to RGB with integer arithmetic, then to the destination space.
  function automatic bund_t model(input int c1, input int c2, input int c3,
                                  input int src, input int dst, input int user);
    int r, g, b, o1, o2, o3, dcb, dcr;
    bit err;
    err = (src == 3) || (dst == 3);
    o1 = c1; o2 = c2; o3 = c3;
    r = c1; g = c2; b = c3;
    if (!err && src != dst) begin
      if (src == 2) begin
        r = MAXV - c1; g = MAXV - c2; b = MAXV - c3;
      end else if (src == 1) begin
        dcb = c2 - OFFV;
        dcr = c3 - OFFV;
        r = clampi(c1 + rnd8(359 * dcr));
        g = clampi(c1 - rnd8(88 * dcb + 183 * dcr));
        b = clampi(c1 + rnd8(454 * dcb));
      end
      if (dst == 1) begin
        o1 = clampi(rnd8(77 * r + 150 * g + 29 * b));
        o2 = clampi(rnd8(-43 * r - 85 * g + 128 * b) + OFFV);
        o3 = clampi(rnd8(128 * r - 107 * g - 21 * b) + OFFV);
      end else if (dst == 2) begin
        o1 = MAXV - r; o2 = MAXV - g; o3 = MAXV - b;
      end else begin
        o1 = r; o2 = g; o3 = b;
      end
    end
    return pack(o1, o2, o3, user, err);
  endfunction

  task automatic check(input string name, input bund_t act, input bund_t expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic send(input int a, input int b, input int c, input int s, input int d,
                      input int u, input bund_t expv);
    bit done;
    done     = 1'b0;
    in_c1    = a[DW-1:0];
    in_c2    = b[DW-1:0];
    in_c3    = c[DW-1:0];
    in_src   = s[1:0];
    in_dst   = d[1:0];
    in_user  = u[UW-1:0];
    in_valid = 1'b1;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(expv);
        acc_q.push_back(cyc);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_accept", bund_t'(done), bund_t'(1));
  endtask

  task automatic send_rand();
    int a, b, c, s, d, u;
    a = $urandom_range(0, MAXV);
    b = $urandom_range(0, MAXV);
    c = $urandom_range(0, MAXV);
    s = $urandom_range(0, 3);
    d = $urandom_range(0, 3);
    u = $urandom_range(0, 2 ** UW - 1);
    send(a, b, c, s, d, u, model(a, b, c, s, d, u));
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", bund_t'(exp_q.size()), bund_t'(0));
  endtask

  // Monitor: compare the front expectation whenever a beat is presented, pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", pack(out_c1, out_c2, out_c3, out_user, out_err), '0);
          if (out_ready == 1'b0) begin
            n_checks++;
          end
        end else begin
          check("out_beat", pack(out_c1, out_c2, out_c3, out_user, out_err), exp_q[0]);
          if (lat_chk && !front_seen) begin
            check("latency", bund_t'(cyc - acc_q[0]), bund_t'(4));
          end
          front_seen = 1'b1;
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            front_seen = 1'b0;
          end
        end
      end
    end
  end

  // Output throttling while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (thr) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_c1 = '0; in_c2 = '0; in_c3 = '0; in_src = '0; in_dst = '0; in_user = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", pack(out_c1, out_c2, out_c3, out_user, out_err), '0);
    check("reset_valid", bund_t'(out_valid), bund_t'(0));
    check("reset_ready", bund_t'(in_ready), bund_t'(1));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Mixed-mode back-to-back stream with incrementing sideband.
    lat_chk = 1'b1;
    send(255, 255, 255, 0, 1, 0, pack(255, 128, 128, 0, 1'b0));
    send(255,   0,   0, 0, 1, 1, pack( 77,  85, 255, 1, 1'b0));
    send(  0, 255, 255, 1, 0, 2, pack(178,   0, 225, 2, 1'b0));
    send(128, 128, 128, 1, 0, 3, pack(128, 128, 128, 3, 1'b0));
    send(  0,   0,   0, 2, 1, 0, pack(255, 128, 128, 0, 1'b0));
    send( 10,  20,  30, 0, 2, 1, pack(245, 235, 225, 1, 1'b0));
    send( 17,   3, 250, 1, 1, 2, pack( 17,   3, 250, 2, 1'b0));
    send(  1,   2,   3, 3, 1, 3, pack(  1,   2,   3, 3, 1'b1));
    drain();
    lat_chk = 1'b0;

    // Throttled random traffic.
    thr = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      send_rand();
    end
    thr = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with three beats in flight and the output stalled.
    out_ready = 1'b0;
    send(200, 100, 50, 0, 0, 1, pack(200, 100, 50, 1, 1'b0));
    send(201, 101, 51, 0, 0, 2, pack(201, 101, 51, 2, 1'b0));
    send(202, 102, 52, 0, 0, 3, pack(202, 102, 52, 3, 1'b0));
    @(posedge clk);
    #1;
    check("stalled_valid", bund_t'(out_valid), bund_t'(1));
    reset_n = 1'b0;
    #1;
    check("midreset_out", pack(out_c1, out_c2, out_c3, out_user, out_err), '0);
    check("midreset_valid", bund_t'(out_valid), bund_t'(0));
    check("midreset_ready", bund_t'(in_ready), bund_t'(1));
    exp_q.delete();
    acc_q.delete();
    front_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("no_ghost", bund_t'(out_valid), bund_t'(0));
    send(  0, 128, 255, 0, 2, 1, pack(255, 127, 0, 1, 1'b0));
    send(  5,   6,   7, 2, 0, 2, pack(250, 249, 248, 2, 1'b0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
